// File: rtl/id_stage.sv
// Instruction-decode stage: decodes one RV64I instruction per cycle into the
// ID/EX boundary register with a valid/ready handshake, branch flush and a
// sticky halt on the all-zero instruction.
module id_stage #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_npc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_npc,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic [XLEN-1:0]        out_imm,
  output logic [6:0]             out_opcode,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_funct7,
  output logic [2:0]             out_fmt,
  output logic                   out_rd_we,
  output logic [4:0]             out_ctrl,
  output logic                   out_illegal,
  output logic                   halt
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [0:0]      state;
  logic            accept;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]      d_fmt;
  logic [XLEN-1:0] d_imm;
  logic [4:0]      d_ctrl;
  logic            d_illegal;
  logic            d_rd_we;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];

  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Ready ignores in_valid so fetch can use it without a combinational loop.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign halt     = (state == HALT);

  // Opcode decode into format, control flags and immediate.
  always_comb begin
    d_fmt     = FMT_I;
    d_ctrl    = 5'b0;
    d_illegal = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111: d_fmt = FMT_U;
      7'b1101111: begin d_fmt = FMT_J; d_ctrl = 5'b00010; end
      7'b1100111: begin d_fmt = FMT_I; d_ctrl = 5'b00001; end
      7'b0000011: begin d_fmt = FMT_I; d_ctrl = 5'b10000; end
      7'b0010011, 7'b0011011: d_fmt = FMT_I;
      7'b0100011: begin d_fmt = FMT_S; d_ctrl = 5'b01000; end
      7'b1100011: begin d_fmt = FMT_B; d_ctrl = 5'b00100; end
      7'b0110011, 7'b0111011: d_fmt = FMT_R;
      default: d_illegal = 1'b1;
    endcase

    case (d_fmt)
      FMT_S:   d_imm = imm_s;
      FMT_B:   d_imm = imm_b;
      FMT_U:   d_imm = imm_u;
      FMT_J:   d_imm = imm_j;
      FMT_R:   d_imm = '0;
      default: d_imm = imm_i;
    endcase

    // x0 is never written; illegal encodings never write.
    d_rd_we = (d_fmt != FMT_S) && (d_fmt != FMT_B) && !d_illegal && (rd != 5'd0);
  end

  // Handshake, halt FSM and ID/EX bundle register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_npc     <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_fmt     <= '0;
      out_rd_we   <= 1'b0;
      out_ctrl    <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_npc     <= in_npc;
      out_rs1     <= in_instr[19:15];
      out_rs2     <= in_instr[24:20];
      out_rd      <= rd;
      out_imm     <= d_imm;
      out_opcode  <= opcode;
      out_funct3  <= in_instr[14:12];
      out_funct7  <= in_instr[31:25];
      out_fmt     <= d_fmt;
      out_rd_we   <= d_rd_we;
      out_ctrl    <= d_ctrl;
      out_illegal <= d_illegal;
      if (in_instr == '0) state <= HALT;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model with arithmetic decode.
module tb_id_stage;

  typedef struct {
    logic [63:0] pc, npc, imm;
    logic [4:0]  rs1, rs2, rd, ctrl;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3, fmt;
    logic        rd_we, illegal;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready, halt;
  logic [31:0] in_instr;
  logic [63:0] in_pc, in_npc, out_pc, out_npc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_ctrl;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_fmt;
  logic        out_rd_we, out_illegal;

  int tests = 0;
  int fails = 0;

  bundle_t q[$];
  logic    m_halt = 1'b0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(64), .INSTR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_npc(in_npc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_npc(out_npc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_fmt(out_fmt), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl),
    .out_illegal(out_illegal), .halt(halt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode from the ISA field rules, using plain arithmetic.
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                         input logic [63:0] npc);
    bundle_t b;
    longint  v;
    bit      writes;
    b.pc = pc; b.npc = npc;
    b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
    b.opcode = ins[6:0]; b.funct3 = ins[14:12]; b.funct7 = ins[31:25];
    b.ctrl = 0; b.illegal = 0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: b.fmt = 4;
      7'b1101111: begin b.fmt = 5; b.ctrl = 2; end
      7'b1100111: begin b.fmt = 1; b.ctrl = 1; end
      7'b0000011: begin b.fmt = 1; b.ctrl = 16; end
      7'b0010011, 7'b0011011: b.fmt = 1;
      7'b0100011: begin b.fmt = 2; b.ctrl = 8; end
      7'b1100011: begin b.fmt = 3; b.ctrl = 4; end
      7'b0110011, 7'b0111011: b.fmt = 0;
      default: begin b.fmt = 1; b.illegal = 1; end
    endcase
    case (b.fmt)
      0: v = 0;
      2: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) v -= 4096;
      end
      3: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (ins[31]) v -= 8192;
      end
      4: begin
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= (longint'(1) << 32);
      end
      5: begin
        v = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (ins[31]) v -= (1 << 21);
      end
      default: begin
        v = longint'(ins[31:20]);
        if (ins[31]) v -= 4096;
      end
    endcase
    b.imm = v;
    writes = (b.fmt == 0) || (b.fmt == 1) || (b.fmt == 4) || (b.fmt == 5);
    b.rd_we = writes && !b.illegal && (b.rd != 0);
    return b;
  endfunction

  // One clock: drive, check ready, clock, update model, check registered outputs.
  task automatic cyc(input logic rst, input logic iv, input logic [31:0] ins,
                     input logic ordy, input logic fl);
    logic    exp_ready;
    bundle_t b;
    logic [63:0] pc;
    pc = {32'h0, $urandom} & ~64'h3;
    reset = rst; in_valid = iv; in_instr = ins; in_pc = pc; in_npc = pc + 4;
    out_ready = ordy; flush = fl;
    #1;
    exp_ready = !m_halt && (q.size() == 0 || ordy);
    if (rst) chk("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_halt = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && exp_ready) begin
        b = ref_decode(ins, pc, pc + 4);
        q.push_back(b);
        if (ins == 0) m_halt = 1;
      end
    end
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("halt", halt, m_halt);
    if (!rst) begin
      chk("rst_data", {out_pc | out_npc | out_imm}, 64'h0);
      chk("rst_fields", {out_rs1, out_rs2, out_rd, out_ctrl, out_opcode, out_funct7,
                         out_funct3, out_fmt, out_rd_we, out_illegal}, 64'h0);
    end else if (q.size() != 0) begin
      b = q[0];
      chk("pc", out_pc, b.pc);
      chk("npc", out_npc, b.npc);
      chk("imm", out_imm, b.imm);
      chk("regs", {out_rs1, out_rs2, out_rd}, {b.rs1, b.rs2, b.rd});
      chk("fields", {out_opcode, out_funct3, out_funct7}, {b.opcode, b.funct3, b.funct7});
      chk("fmt", out_fmt, b.fmt);
      chk("rd_we", out_rd_we, b.rd_we);
      chk("ctrl", out_ctrl, b.ctrl);
      chk("illegal", out_illegal, b.illegal);
    end
  endtask

  logic [6:0]  ops [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                            7'b0010011, 7'b0011011, 7'b0100011, 7'b1100011, 7'b0110011,
                            7'b0111011, 7'b1111111};
  logic [31:0] ri;

  initial begin
    reset = 0; in_valid = 0; in_instr = 0; in_pc = 0; in_npc = 0; flush = 0; out_ready = 0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 32'h00500093, 1, 0);
    chk("reset_in_ready", in_ready, 1'b1);

    // Directed decode cases.
    cyc(1, 1, 32'h00500093, 1, 0);
    chk("addi_imm", out_imm, 64'h5);
    chk("addi_rd_rs1", {out_rd, out_rs1}, {5'd1, 5'd0});
    chk("addi_fmt_we", {out_fmt, out_rd_we}, {3'd1, 1'b1});
    cyc(1, 1, 32'hFE000EE3, 1, 0);
    chk("beq_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_fmt_ctrl", {out_fmt, out_ctrl, out_rd_we}, {3'd3, 5'b00100, 1'b0});
    cyc(1, 1, 32'h800002B7, 1, 0);
    chk("lui_imm", out_imm, 64'hFFFFFFFF80000000);
    chk("lui_rd", out_rd, 5'd5);

    // Stall three cycles with fetch pushing, then release back-to-back.
    cyc(1, 1, 32'h00A00113, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h00300193, 0, 0);
    cyc(1, 1, 32'h00300193, 1, 0);
    cyc(1, 1, 32'h00400213, 1, 0);

    // Flush kills the held bundle and the incoming instruction.
    cyc(1, 1, 32'h00100293, 0, 0);
    cyc(1, 1, 32'h00200313, 0, 1);
    cyc(1, 0, 32'h0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      ri[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
      if (ri == 0) ri = 32'h13;
      cyc(1, $urandom_range(0, 3) != 0, ri, $urandom_range(0, 2) != 0,
          $urandom_range(0, 7) == 0);
    end

    // Reset while stalled discards the held bundle.
    cyc(1, 1, 32'h00700393, 0, 0);
    cyc(1, 1, 32'h00800413, 0, 0);
    cyc(0, 1, 32'h00800413, 0, 0);

    // Halt instruction dropped by a same-cycle flush.
    cyc(1, 1, 32'h0, 1, 1);
    cyc(1, 0, 32'h0, 1, 0);

    // Halt instruction accepted: sticky halt until reset.
    cyc(1, 1, 32'h0, 1, 0);
    chk("halt_illegal", out_illegal, 1'b1);
    chk("halt_flag", halt, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h00500093, 1, 0);
    chk("halt_no_ready", in_ready, 1'b0);
    cyc(0, 1, 32'h00500093, 1, 0);
    chk("halt_cleared", halt, 1'b0);
    cyc(1, 1, 32'h00500093, 1, 0);
    cyc(1, 0, 32'h0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
